mc_port_arbiter: RTL and testbench

Shares one Convey MC request/response port between NUM_REQ phold event-processing requesters. Round-robin arbitration, a one-deep registered request stage and a one-deep registered response stage. Requester IDs are carried in the upper rtnctl bits so that responses route back to the issuer. Per-requester outstanding-request limiting prevents any single requester from monopolising MC tags. Sits between the phold core array and one mc_rq_*/mc_rs_* lane of cae_pers.

---
 rtl/mc_arb_pkg.sv | 42 ++++
 rtl/mc_port_arbiter_if.sv | 76 +++++++
 rtl/mc_port_arbiter_rr_arbiter.sv | 39 +++
 rtl/mc_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mc_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_arb_pkg.sv
// ============================================================================
// Package  : mc_arb_pkg
// Brief    : Shared MC command codes, rtnctl ID placement and payload types
//            for the MC port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_arb_pkg;

    localparam logic [2:0] c_mc_cmd_rd   = 3'd1;
    localparam logic [2:0] c_mc_cmd_wr   = 3'd2;
    localparam logic [2:0] c_mc_cmd_rd64 = 3'd6;
    localparam logic [2:0] c_mc_cmd_wr64 = 3'd7;

    localparam int c_out_cnt_w = 8;
    localparam int c_stat_w    = 32;

    typedef logic [c_out_cnt_w-1:0] out_cnt_t;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [3:0]  scmd;
        logic [1:0]  size;
        logic [47:0] vadr;
        logic [63:0] data;
    } mc_rq_fields_t;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [3:0]  scmd;
        logic [63:0] data;
    } mc_rs_fields_t;

    // The requester ID occupies the top ID bits of rtnctl.
    function automatic int rtnctl_id_lsb(input int rtnctl_width, input int id_w);
        return rtnctl_width - id_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_port_arbiter_if.sv
// ============================================================================
// Interface : mc_port_arbiter_if
// Brief     : Requester-array and MC-lane signals of the MC port arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_port_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int RTNCTL_WIDTH = 32,
    parameter int ID_W         = $clog2(NUM_REQ)
);
    localparam int c_tag_w = RTNCTL_WIDTH - ID_W;

    // requester side
    logic [NUM_REQ-1:0]              req_vld;
    logic [NUM_REQ-1:0][2:0]         req_cmd;
    logic [NUM_REQ-1:0][3:0]         req_scmd;
    logic [NUM_REQ-1:0][1:0]         req_size;
    logic [NUM_REQ-1:0][47:0]        req_vadr;
    logic [NUM_REQ-1:0][63:0]        req_data;
    logic [NUM_REQ-1:0][c_tag_w-1:0] req_rtnctl;
    logic [NUM_REQ-1:0]              req_stall;

    logic [NUM_REQ-1:0]              rsp_vld;
    logic [2:0]                      rsp_cmd;
    logic [3:0]                      rsp_scmd;
    logic [63:0]                     rsp_data;
    logic [c_tag_w-1:0]              rsp_rtnctl;
    logic [NUM_REQ-1:0]              rsp_stall;

    // MC side
    logic                            mc_rq_vld;
    logic [2:0]                      mc_rq_cmd;
    logic [3:0]                      mc_rq_scmd;
    logic [1:0]                      mc_rq_size;
    logic [47:0]                     mc_rq_vadr;
    logic [63:0]                     mc_rq_data;
    logic [RTNCTL_WIDTH-1:0]         mc_rq_rtnctl;
    logic                            mc_rq_flush;
    logic                            mc_rq_stall;

    logic                            mc_rs_vld;
    logic [2:0]                      mc_rs_cmd;
    logic [3:0]                      mc_rs_scmd;
    logic [63:0]                     mc_rs_data;
    logic [RTNCTL_WIDTH-1:0]         mc_rs_rtnctl;
    logic                            mc_rs_stall;

    modport slave (
        input  req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_rtnctl,
        output req_stall,
        output rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
        input  rsp_stall,
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data,
        output mc_rq_rtnctl, mc_rq_flush,
        input  mc_rq_stall,
        input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
        output mc_rs_stall
    );

    modport master (
        output req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_rtnctl,
        input  req_stall,
        input  rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
        output rsp_stall,
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data,
        input  mc_rq_rtnctl, mc_rq_flush,
        output mc_rq_stall,
        output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
        input  mc_rs_stall
    );

endinterface

`default_nettype wire

// File: rtl/mc_port_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker: first eligible index at or
//            after ptr, wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  wire  [N-1:0]  eligible,
    input  wire  [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner,
    output logic          any_grant
);

    logic [PW-1:0] w_idx;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        w_idx     = ptr;
        for (int k = 0; k < N; k++) begin
            if (!any_grant && eligible[w_idx]) begin
                any_grant     = 1'b1;
                grant[w_idx]  = 1'b1;
                winner        = w_idx;
            end
            w_idx = (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc_port_arbiter.sv
// ============================================================================
// Module   : mc_port_arbiter
// Brief    : Shares one MC request/response lane between NUM_REQ requesters
//            with round-robin grants, per-requester outstanding limits and
//            registered request/response stages.
// Options  : MC_ARB_STATS_EN adds grant and MC-stall statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_port_arbiter
    import mc_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int RTNCTL_WIDTH = 32,
    parameter int ID_W         = $clog2(NUM_REQ),
    parameter int MAX_OUT      = 16
) (
    input  wire                                clk,
    input  wire                                rst_n,
    mc_port_arbiter_if.slave                   bus,
    output logic [NUM_REQ-1:0][c_stat_w-1:0]   stat_grants,
    output logic [c_stat_w-1:0]                stat_stall_cycles
);

    localparam int       c_id_lsb  = rtnctl_id_lsb(RTNCTL_WIDTH, ID_W);
    localparam int       c_tag_w   = c_id_lsb;
    localparam out_cnt_t c_max_out = out_cnt_t'(MAX_OUT);

    logic [ID_W-1:0]              r_ptr;
    out_cnt_t [NUM_REQ-1:0]       r_out_cnt;

    logic                         r_rq_vld;
    mc_rq_fields_t                r_rq;
    logic [RTNCTL_WIDTH-1:0]      r_rq_rtnctl;

    logic                         r_rs_vld;
    logic [ID_W-1:0]              r_rs_dest;
    mc_rs_fields_t                r_rs;
    logic [c_tag_w-1:0]           r_rs_tag;

    logic [NUM_REQ-1:0]           w_eligible;
    logic [NUM_REQ-1:0]           w_grant_raw;
    logic [NUM_REQ-1:0]           w_grant;
    logic [NUM_REQ-1:0]           w_deliver;
    logic [NUM_REQ-1:0]           w_rsp_vld;
    logic [ID_W-1:0]              w_winner;
    logic                         w_any_raw;
    logic                         w_slot;
    logic                         w_grant_vld;
    mc_rq_fields_t                w_rq_sel;

    logic [ID_W-1:0]              w_rs_id;
    logic                         w_rs_id_ok;
    logic                         w_rs_stall;
    logic                         w_rs_xfer;
    logic                         w_rs_accept;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    always_comb begin
        w_eligible = '0;
        w_deliver  = '0;
        w_rsp_vld  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = bus.req_vld[i] && (r_out_cnt[i] < c_max_out);
            w_deliver[i]  = w_rs_xfer && (int'(r_rs_dest) == i);
            w_rsp_vld[i]  = r_rs_vld && (int'(r_rs_dest) == i);
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_rr_arbiter (
        .eligible  (w_eligible),
        .ptr       (r_ptr),
        .grant     (w_grant_raw),
        .winner    (w_winner),
        .any_grant (w_any_raw)
    );

    // A grant needs somewhere to land: an empty register or one the MC is taking now.
    assign w_slot      = !r_rq_vld || !bus.mc_rq_stall;
    assign w_grant_vld = w_any_raw && w_slot;
    assign w_grant     = w_slot ? w_grant_raw : '0;

    always_comb begin
        w_rq_sel      = '0;
        w_rq_sel.cmd  = bus.req_cmd[w_winner];
        w_rq_sel.scmd = bus.req_scmd[w_winner];
        w_rq_sel.size = bus.req_size[w_winner];
        w_rq_sel.vadr = bus.req_vadr[w_winner];
        w_rq_sel.data = bus.req_data[w_winner];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rq_vld    <= 1'b0;
            r_rq        <= '0;
            r_rq_rtnctl <= '0;
            r_ptr       <= '0;
        end else if (w_grant_vld) begin
            r_rq_vld    <= 1'b1;
            r_rq        <= w_rq_sel;
            r_rq_rtnctl <= {w_winner, bus.req_rtnctl[w_winner]};
            r_ptr       <= (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + ID_W'(1);
        end else if (!bus.mc_rq_stall) begin
            r_rq_vld    <= 1'b0;
        end
    end

    // Outstanding count; a delivery with the count already at zero is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && !w_deliver[i]) begin
                    r_out_cnt[i] <= r_out_cnt[i] + out_cnt_t'(1);
                end else if (!w_grant[i] && w_deliver[i] && (r_out_cnt[i] != '0)) begin
                    r_out_cnt[i] <= r_out_cnt[i] - out_cnt_t'(1);
                end
            end
        end
    end

    assign bus.req_stall    = ~w_grant;
    assign bus.mc_rq_vld    = r_rq_vld;
    assign bus.mc_rq_cmd    = r_rq.cmd;
    assign bus.mc_rq_scmd   = r_rq.scmd;
    assign bus.mc_rq_size   = r_rq.size;
    assign bus.mc_rq_vadr   = r_rq.vadr;
    assign bus.mc_rq_data   = r_rq.data;
    assign bus.mc_rq_rtnctl = r_rq_rtnctl;
    assign bus.mc_rq_flush  = 1'b0;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    assign w_rs_id     = bus.mc_rs_rtnctl[c_id_lsb +: ID_W];
    assign w_rs_id_ok  = int'(w_rs_id) < NUM_REQ;
    assign w_rs_stall  = r_rs_vld && bus.rsp_stall[r_rs_dest];
    assign w_rs_xfer   = r_rs_vld && !bus.rsp_stall[r_rs_dest];
    assign w_rs_accept = bus.mc_rs_vld && !w_rs_stall;

    // Responses carrying an out-of-range ID are consumed without a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_vld  <= 1'b0;
            r_rs_dest <= '0;
            r_rs      <= '0;
            r_rs_tag  <= '0;
        end else if (w_rs_accept) begin
            r_rs_vld <= w_rs_id_ok;
            if (w_rs_id_ok) begin
                r_rs_dest <= w_rs_id;
                r_rs.cmd  <= bus.mc_rs_cmd;
                r_rs.scmd <= bus.mc_rs_scmd;
                r_rs.data <= bus.mc_rs_data;
                r_rs_tag  <= bus.mc_rs_rtnctl[c_tag_w-1:0];
            end
        end else if (w_rs_xfer) begin
            r_rs_vld <= 1'b0;
        end
    end

    assign bus.rsp_vld     = w_rsp_vld;
    assign bus.rsp_cmd     = r_rs.cmd;
    assign bus.rsp_scmd    = r_rs.scmd;
    assign bus.rsp_data    = r_rs.data;
    assign bus.rsp_rtnctl  = r_rs_tag;
    assign bus.mc_rs_stall = w_rs_stall;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef MC_ARB_STATS_EN
    logic [NUM_REQ-1:0][c_stat_w-1:0] r_stat_grants;
    logic [c_stat_w-1:0]              r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_grants <= '0;
            r_stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && (r_stat_grants[i] != '1)) begin
                    r_stat_grants[i] <= r_stat_grants[i] + c_stat_w'(1);
                end
            end
            if (r_rq_vld && bus.mc_rq_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + c_stat_w'(1);
            end
        end
    end

    assign stat_grants       = r_stat_grants;
    assign stat_stall_cycles = r_stat_stall;
`else
    assign stat_grants       = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_port_arbiter.sv
// ============================================================================
// Module   : tb_mc_port_arbiter
// Brief    : Directed vector bench for mc_port_arbiter (4 requesters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_port_arbiter;
    import mc_arb_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int RTNCTL_WIDTH = 32;
    localparam int ID_W         = 2;
    localparam int MAX_OUT      = 16;
    localparam int TAG_W        = RTNCTL_WIDTH - ID_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_port_arbiter_if #(.NUM_REQ(NUM_REQ), .RTNCTL_WIDTH(RTNCTL_WIDTH), .ID_W(ID_W)) bus();

    logic [NUM_REQ-1:0][31:0] stat_grants;
    logic [31:0]              stat_stall_cycles;

    mc_port_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .RTNCTL_WIDTH (RTNCTL_WIDTH),
        .ID_W         (ID_W),
        .MAX_OUT      (MAX_OUT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .stat_grants       (stat_grants),
        .stat_stall_cycles (stat_stall_cycles)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0] vld;
        logic       rq_stall;
        logic [3:0] exp_stall;
        logic       exp_vld;
        logic [1:0] exp_id;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.req_vld      = '0;
        bus.mc_rq_stall  = 1'b0;
        bus.mc_rs_vld    = 1'b0;
        bus.mc_rs_cmd    = '0;
        bus.mc_rs_scmd   = '0;
        bus.mc_rs_data   = '0;
        bus.mc_rs_rtnctl = '0;
        bus.rsp_stall    = '0;
    endtask

    task automatic set_rs(input logic v, input logic [1:0] id, input logic [29:0] tag,
                          input logic [63:0] d);
        bus.mc_rs_vld    = v;
        bus.mc_rs_cmd    = c_mc_cmd_wr;
        bus.mc_rs_scmd   = 4'h0;
        bus.mc_rs_rtnctl = {id, tag};
        bus.mc_rs_data   = d;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ng;
        int nstall;

        idle();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_cmd[i]    = c_mc_cmd_rd;
            bus.req_scmd[i]   = 4'h0;
            bus.req_size[i]   = 2'd3;
            bus.req_vadr[i]   = 48'(i) << 12;
            bus.req_data[i]   = 64'hA0 + 64'(i);
            bus.req_rtnctl[i] = TAG_W'(32'h100 + 32'(i));
        end

        //                 vld      stall  exp_stall exp_vld exp_id
        tbl[0]  = '{4'b1111, 1'b0, 4'b1110, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b1101, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 1'b0, 4'b1011, 1'b1, 2'd1};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0111, 1'b1, 2'd2};
        tbl[4]  = '{4'b1111, 1'b0, 4'b1110, 1'b1, 2'd3};
        tbl[5]  = '{4'b0100, 1'b0, 4'b1011, 1'b1, 2'd0};
        tbl[6]  = '{4'b0011, 1'b0, 4'b1110, 1'b1, 2'd2};
        tbl[7]  = '{4'b0000, 1'b0, 4'b1111, 1'b1, 2'd0};
        tbl[8]  = '{4'b1001, 1'b0, 4'b0111, 1'b0, 2'd0};
        tbl[9]  = '{4'b1001, 1'b1, 4'b1111, 1'b1, 2'd3};
        tbl[10] = '{4'b1001, 1'b0, 4'b1110, 1'b1, 2'd3};
        tbl[11] = '{4'b1001, 1'b0, 4'b0111, 1'b1, 2'd0};
        tbl[12] = '{4'b0000, 1'b0, 4'b1111, 1'b1, 2'd3};
        tbl[13] = '{4'b0000, 1'b0, 4'b1111, 1'b0, 2'd0};

        // Reset state
        #3;
        chk("rst mc_rq_vld", 64'(bus.mc_rq_vld), 64'd0);
        chk("rst rsp_vld", 64'(bus.rsp_vld), 64'd0);
        do_reset();
        settle();
        chk("rst mc_rq_vld after", 64'(bus.mc_rq_vld), 64'd0);
        chk("rst mc_rs_stall", 64'(bus.mc_rs_stall), 64'd0);
        chk("rst mc_rq_flush", 64'(bus.mc_rq_flush), 64'd0);
        chk("rst mc_rq_rtnctl", 64'(bus.mc_rq_rtnctl), 64'd0);
        chk("rst rsp_data", bus.rsp_data, 64'd0);
        chk("rst req_stall idle", 64'(bus.req_stall), 64'hF);
        chk("rst stat_stall", 64'(stat_stall_cycles), 64'd0);
        chk("rst stat_grants", 64'(stat_grants[0]) | 64'(stat_grants[3]), 64'd0);

        // Round-robin vector table
        nstall = 0;
        for (int v = 0; v < 14; v++) begin
            bus.req_vld     = tbl[v].vld;
            bus.mc_rq_stall = tbl[v].rq_stall;
            settle();
            chk($sformatf("rr%0d req_stall", v), 64'(bus.req_stall), 64'(tbl[v].exp_stall));
            chk($sformatf("rr%0d mc_rq_vld", v), 64'(bus.mc_rq_vld), 64'(tbl[v].exp_vld));
            if (tbl[v].exp_vld) begin
                chk($sformatf("rr%0d id", v), 64'(bus.mc_rq_rtnctl[31:30]), 64'(tbl[v].exp_id));
                chk($sformatf("rr%0d tag", v), 64'(bus.mc_rq_rtnctl[29:0]),
                    64'(32'h100 + 32'(tbl[v].exp_id)));
                chk($sformatf("rr%0d vadr", v), 64'(bus.mc_rq_vadr), 64'(tbl[v].exp_id) << 12);
                if (tbl[v].rq_stall) nstall++;
            end
            tick();
        end
        bus.req_vld = '0;
        settle();
        chk("rr out_cnt0", 64'(dut.r_out_cnt[0]), 64'd4);
        chk("rr out_cnt1", 64'(dut.r_out_cnt[1]), 64'd1);
        chk("rr out_cnt2", 64'(dut.r_out_cnt[2]), 64'd2);
        chk("rr out_cnt3", 64'(dut.r_out_cnt[3]), 64'd3);
`ifdef MC_ARB_STATS_EN
        chk("stat_grants0", 64'(stat_grants[0]), 64'd4);
        chk("stat_grants3", 64'(stat_grants[3]), 64'd3);
        chk("stat_stall rr", 64'(stat_stall_cycles), 64'(nstall));
`else
        chk("stat_grants off", 64'(stat_grants[0]), 64'd0);
`endif

        // MC stall held 5 cycles with a full register
        do_reset();
        bus.req_vld = 4'b0001;
        settle();
        chk("hold grant0", 64'(bus.req_stall), 64'hE);
        tick();
        bus.req_vld     = 4'b0110;
        bus.mc_rq_stall = 1'b1;
        ng = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            if (bus.req_stall == 4'b1111 && bus.mc_rq_vld == 1'b1 &&
                bus.mc_rq_rtnctl == 32'h0000_0100 && bus.mc_rq_vadr == 48'h0 &&
                bus.mc_rq_data == 64'hA0) ng++;
            tick();
        end
        chk("hold stable cycles", 64'(ng), 64'd5);
        bus.mc_rq_stall = 1'b0;
        settle();
        chk("hold release grant1", 64'(bus.req_stall), 64'hD);
        tick();
        bus.req_vld = '0;
        settle();
        chk("hold next id1", 64'(bus.mc_rq_rtnctl[31:30]), 64'd1);
`ifdef MC_ARB_STATS_EN
        chk("stat_stall 5", 64'(stat_stall_cycles), 64'd5);
`else
        chk("stat_stall off", 64'(stat_stall_cycles), 64'd0);
`endif
        tick();

        // Outstanding limit on requester 2
        do_reset();
        ng = 0;
        for (int k = 0; k < 16; k++) begin
            bus.req_vld = 4'b0100;
            settle();
            if (bus.req_stall[2] == 1'b0) ng++;
            tick();
        end
        chk("limit 16 grants", 64'(ng), 64'd16);
        bus.req_vld = 4'b0101;
        settle();
        chk("limit out_cnt2", 64'(dut.r_out_cnt[2]), 64'd16);
        chk("limit 17th stalls", 64'(bus.req_stall), 64'hE);
        tick();
        bus.req_vld = 4'b0100;
        set_rs(1'b1, 2'd2, 30'h55, 64'h1234);
        settle();
        chk("limit still blocked", 64'(bus.req_stall), 64'hF);
        tick();
        set_rs(1'b0, 2'd0, 30'h0, 64'h0);
        settle();
        chk("limit rsp_vld2", 64'(bus.rsp_vld), 64'h4);
        chk("limit rsp tag", 64'(bus.rsp_rtnctl), 64'h55);
        chk("limit blocked during rsp", 64'(bus.req_stall), 64'hF);
        tick();
        settle();
        chk("limit regrant 2", 64'(bus.req_stall), 64'hB);
        tick();
        bus.req_vld = '0;

        // Response stalled by destination 1 for 3 cycles, then back-to-back
        do_reset();
        set_rs(1'b1, 2'd1, 30'h3ABCDEF, 64'hDEAD_BEEF_0000_0001);
        bus.rsp_stall = 4'b0010;
        settle();
        chk("rs empty no stall", 64'(bus.mc_rs_stall), 64'd0);
        tick();
        set_rs(1'b1, 2'd3, 30'h77, 64'h3333);
        ng = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            if (bus.rsp_vld == 4'b0010 && bus.mc_rs_stall == 1'b1 &&
                bus.rsp_rtnctl == 30'h3ABCDEF && bus.rsp_data == 64'hDEAD_BEEF_0000_0001 &&
                bus.rsp_cmd == c_mc_cmd_wr) ng++;
            tick();
        end
        chk("rs held 3 cycles", 64'(ng), 64'd3);
        bus.rsp_stall = '0;
        settle();
        chk("rs release stall", 64'(bus.mc_rs_stall), 64'd0);
        chk("rs release vld", 64'(bus.rsp_vld), 64'h2);
        tick();
        set_rs(1'b0, 2'd0, 30'h0, 64'h0);
        settle();
        chk("rs b2b vld3", 64'(bus.rsp_vld), 64'h8);
        chk("rs b2b tag", 64'(bus.rsp_rtnctl), 64'h77);
        tick();
        settle();
        chk("rs empty after", 64'(bus.rsp_vld), 64'h0);
        chk("rs stray out_cnt3", 64'(dut.r_out_cnt[3]), 64'd0);
        tick();

        // Simultaneous grant and delivery for requester 0
        do_reset();
        bus.req_vld = 4'b0001;
        tick();
        bus.req_vld = '0;
        set_rs(1'b1, 2'd0, 30'h10, 64'h0);
        tick();
        set_rs(1'b0, 2'd0, 30'h0, 64'h0);
        bus.req_vld = 4'b0001;
        settle();
        chk("same rsp_vld0", 64'(bus.rsp_vld), 64'h1);
        chk("same grant0", 64'(bus.req_stall), 64'hE);
        tick();
        bus.req_vld = '0;
        settle();
        chk("same out_cnt0", 64'(dut.r_out_cnt[0]), 64'd1);
        tick();

        // Asynchronous reset with both registers full
        bus.req_vld = 4'b0001;
        set_rs(1'b1, 2'd1, 30'h21, 64'h5);
        bus.rsp_stall = 4'b0010;
        tick();
        bus.req_vld     = '0;
        bus.mc_rq_stall = 1'b1;
        set_rs(1'b0, 2'd0, 30'h0, 64'h0);
        settle();
        chk("arst pre mc_rq_vld", 64'(bus.mc_rq_vld), 64'd1);
        chk("arst pre rsp_vld", 64'(bus.rsp_vld), 64'h2);
        rst_n = 1'b0;
        #1;
        chk("arst mc_rq_vld", 64'(bus.mc_rq_vld), 64'd0);
        chk("arst rsp_vld", 64'(bus.rsp_vld), 64'h0);
        chk("arst mc_rs_stall", 64'(bus.mc_rs_stall), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_rs(1'b1, 2'd3, 30'h99, 64'h9);
        tick();
        set_rs(1'b0, 2'd0, 30'h0, 64'h0);
        settle();
        chk("stray rsp_vld3", 64'(bus.rsp_vld), 64'h8);
        chk("stray tag", 64'(bus.rsp_rtnctl), 64'h99);
        tick();
        settle();
        chk("stray out_cnt3", 64'(dut.r_out_cnt[3]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
